// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS32 sequencer: steps fetch/decode/execute/memory/writeback,
// stalls on mem_ready, and drives all datapath mux selects and write enables.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dest,
  output logic       reg_write,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [2:0] aluop,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [2:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_SW    = 6'h01;
  localparam logic [5:0] OP_LW    = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h05;
  localparam logic [5:0] OP_BEQ   = 6'h06;
  localparam logic [5:0] OP_J     = 6'h07;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6
  } state_t;

  state_t cur, nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  assign state = cur;

  // Outputs decoded from state/opcode/mem_ready; reset forces every strobe low at once.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dest      = 1'b0;
    reg_write     = 1'b0;
    alusrc_a      = 1'b0;
    alusrc_b      = 2'b00;
    aluop         = 3'b000;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    nxt           = S_FETCH;
    if (!rst) begin
      case (cur)
        S_FETCH: begin
          mem_read = 1'b1;
          alusrc_b = 2'b01;
          pc_write = mem_ready;
          ir_write = mem_ready;
          nxt      = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alusrc_b = 2'b11;
          case (opcode)
            OP_BEQ: nxt = S_BRANCH;
            OP_J:   nxt = S_JUMP;
            OP_RTYPE, OP_SW, OP_LW, OP_ADDI, OP_ANDI, OP_ORI: nxt = S_EXEC;
            default: begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
              nxt        = S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          alusrc_a = 1'b1;
          case (opcode)
            OP_RTYPE: begin
              aluop = 3'b010;
              nxt   = S_WB;
            end
            OP_SW, OP_LW: begin
              alusrc_b = 2'b10;
              nxt      = S_MEM;
            end
            OP_ADDI: begin
              alusrc_b = 2'b10;
              nxt      = S_WB;
            end
            OP_ANDI: begin
              alusrc_b = 2'b10;
              aluop    = 3'b011;
              nxt      = S_WB;
            end
            OP_ORI: begin
              alusrc_b = 2'b10;
              aluop    = 3'b100;
              nxt      = S_WB;
            end
            default: nxt = S_FETCH;
          endcase
        end
        S_MEM: begin
          i_or_d = 1'b1;
          if (opcode == OP_LW) begin
            mem_read = 1'b1;
            nxt      = mem_ready ? S_WB : S_MEM;
          end else if (opcode == OP_SW) begin
            mem_write  = 1'b1;
            instr_done = mem_ready;
            nxt        = mem_ready ? S_FETCH : S_MEM;
          end else begin
            nxt = S_FETCH;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          reg_dest   = (opcode == OP_RTYPE);
          mem_to_reg = (opcode == OP_LW);
          nxt        = S_FETCH;
        end
        S_BRANCH: begin
          alusrc_a      = 1'b1;
          aluop         = 3'b001;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
          nxt           = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
        default: nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: per-instruction expected cycle
// traces built from the phase rules, plus latency and instr_done pulse checks.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, reg_dest, reg_write, alusrc_a, instr_done, illegal_op;
  logic [1:0] pc_source, alusrc_b;
  logic [2:0] aluop, state;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dest;
    logic       reg_write;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [2:0] aluop;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  typedef struct packed {
    logic [2:0] st;
    logic       rdy;
  } step_t;

  ctl_t obs;
  int   n_checks = 0;
  int   n_fail   = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dest(reg_dest), .reg_write(reg_write),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
                mem_write, mem_to_reg, reg_dest, reg_write, alusrc_a, alusrc_b,
                aluop, instr_done, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control word for a phase (0 FETCH .. 6 JUMP) under a given opcode and ready.
  function automatic ctl_t exp_ctl(input logic [2:0] st, input logic [5:0] op, input logic rdy);
    ctl_t c = '0;
    case (st)
      3'd0: begin c.mem_read = 1; c.alusrc_b = 2'b01; c.pc_write = rdy; c.ir_write = rdy; end
      3'd1: begin
        c.alusrc_b = 2'b11;
        if (op > 6'd7) begin c.illegal_op = 1; c.instr_done = 1; end
      end
      3'd2: begin
        c.alusrc_a = 1;
        if (op == 6'd0) c.aluop = 3'b010;
        else c.alusrc_b = 2'b10;
        if (op == 6'd4) c.aluop = 3'b011;
        if (op == 6'd5) c.aluop = 3'b100;
      end
      3'd3: begin
        c.i_or_d = 1; c.mem_read = (op == 6'd2); c.mem_write = (op == 6'd1);
        c.instr_done = (op == 6'd1) && rdy;
      end
      3'd4: begin
        c.reg_write = 1; c.instr_done = 1;
        c.reg_dest = (op == 6'd0); c.mem_to_reg = (op == 6'd2);
      end
      3'd5: begin
        c.alusrc_a = 1; c.aluop = 3'b001; c.pc_write_cond = 1;
        c.pc_source = 2'b01; c.instr_done = 1;
      end
      3'd6: begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic int base_latency(input logic [5:0] op);
    case (op)
      6'd0, 6'd1, 6'd3, 6'd4, 6'd5: return 4;
      6'd2:                         return 5;
      6'd6, 6'd7:                   return 3;
      default:                      return 2;
    endcase
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one instruction; entered and left at posedge+1. abort_idx >= 0 asserts rst mid-cycle there.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input int abort_idx);
    step_t tr[$];
    int    lat = 0;
    int    pulses = 0;
    tr = {};
    for (int i = 0; i < fs; i++) tr.push_back('{3'd0, 1'b0});
    tr.push_back('{3'd0, 1'b1});
    tr.push_back('{3'd1, rnd_bit()});
    if (op <= 6'd5) begin
      tr.push_back('{3'd2, rnd_bit()});
      if (op == 6'd1 || op == 6'd2) begin
        for (int i = 0; i < ms; i++) tr.push_back('{3'd3, 1'b0});
        tr.push_back('{3'd3, 1'b1});
      end
      if (op != 6'd1) tr.push_back('{3'd4, rnd_bit()});
    end else if (op == 6'd6) tr.push_back('{3'd5, rnd_bit()});
    else if (op == 6'd7) tr.push_back('{3'd6, rnd_bit()});

    for (int i = 0; i < tr.size(); i++) begin
      mem_ready = tr[i].rdy;
      opcode    = (tr[i].st == 3'd0) ? 6'($urandom_range(0, 63)) : op;
      @(negedge clk);
      check("state", 32'(state), 32'(tr[i].st));
      check("ctl", 32'(obs), 32'(exp_ctl(tr[i].st, op, tr[i].rdy)));
      if (instr_done) begin
        pulses++;
        if (lat == 0) lat = i + 1;
      end
      if (i == abort_idx) begin
        #2 rst = 1'b1;
        #1;
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctl", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_state", 32'(state), 32'd0);
        check("rst_hold_ctl", 32'(obs), 32'd0);
        rst = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("latency", 32'(lat),
          32'(base_latency(op) + fs + ((op == 6'd1 || op == 6'd2) ? ms : 0)));
    check("done_pulses", 32'(pulses), 32'd1);
  endtask

  initial begin
    logic [5:0] op;
    rst       = 1'b1;
    opcode    = 6'h00;
    mem_ready = 1'b1;
    #3;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctl", 32'(obs), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    run_instr(6'h00, 0, 0, -1);   // R-type
    run_instr(6'h02, 0, 2, -1);   // lw, two MEM stalls
    run_instr(6'h01, 0, 0, -1);   // sw
    run_instr(6'h05, 0, 0, -1);   // ori
    run_instr(6'h06, 0, 0, -1);   // beq
    run_instr(6'h07, 0, 0, -1);   // j
    run_instr(6'h2A, 0, 0, -1);   // illegal
    run_instr(6'h02, 3, 1, -1);   // lw with fetch stalls
    run_instr(6'h01, 0, 3, 3);    // sw, reset during MEM stall
    run_instr(6'h00, 1, 0, -1);   // recovers from FETCH

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(8, 63));
      else                           op = 6'($urandom_range(0, 7));
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
